// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
//   mode_t  : operation encodings driven on the mode input
//   state_t : sequencer states (IDLE, RUN)
//   is_shift: true for modes that move bits (repeatable multi-step ops)
package shift_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // HOLD/LOAD/CLR give the same result however often they repeat, so a
  // multi-step request with one of them finishes after a single step.
  function automatic logic is_shift(input mode_t m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
           (m == M_ROR) || (m == M_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus between a controller and univ_shift_reg.
//   master: drives en, mode, D, ser_in_l, ser_in_r, start, amount;
//           observes Q, Q_bar, ser_out, busy, done
//   slave : the shift register side (directions reversed)
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  import shift_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] D;
  logic             ser_in_l;
  logic             ser_in_r;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, D, ser_in_l, ser_in_r, start, amount,
    input  Q, Q_bar, ser_out, busy, done
  );

  modport slave (
    input  en, mode, D, ser_in_l, ser_in_r, start, amount,
    output Q, Q_bar, ser_out, busy, done
  );

endinterface

// File: rtl/univ_shift_reg_step.sv
// Combinational single-step function of the shift register.
//   i_q        : current register contents
//   i_mode     : operation to apply
//   i_d        : parallel load data (LOAD)
//   i_ser_in_l : bit entering the MSB on SHR
//   i_ser_in_r : bit entering the LSB on SHL
//   o_q        : register contents after the step
//   o_ser      : bit that left the register on this step
//   o_ser_vld  : o_ser is meaningful (bit-moving modes only)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ser_in_l,
  input  logic             i_ser_in_r,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ser,
  output logic             o_ser_vld
);

  always_comb begin
    o_q       = i_q;
    o_ser     = 1'b0;
    o_ser_vld = 1'b0;
    case (i_mode)
      M_HOLD: o_q = i_q;
      M_LOAD: o_q = i_d;
      M_SHL: begin
        o_q       = {i_q[WIDTH-2:0], i_ser_in_r};
        o_ser     = i_q[WIDTH-1];
        o_ser_vld = 1'b1;
      end
      M_SHR: begin
        o_q       = {i_ser_in_l, i_q[WIDTH-1:1]};
        o_ser     = i_q[0];
        o_ser_vld = 1'b1;
      end
      M_ROL: begin
        o_q       = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_ser     = i_q[WIDTH-1];
        o_ser_vld = 1'b1;
      end
      M_ROR: begin
        o_q       = {i_q[0], i_q[WIDTH-1:1]};
        o_ser     = i_q[0];
        o_ser_vld = 1'b1;
      end
      M_ASR: begin
        o_q       = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_ser     = i_q[0];
        o_ser_vld = 1'b1;
      end
      M_CLR:   o_q = '0;
      default: o_q = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and multi-step operation.
//   Clk   : clock, all state updates on the rising edge
//   reset : synchronous active-low reset, highest priority
//   bus   : slave side of univ_shift_reg_if
//           en/mode/D/ser_in_l/ser_in_r : single-step control and data
//           start/amount                : launch a multi-step operation
//           Q/Q_bar/ser_out             : register contents, complement,
//                                         last bit shifted out
//           busy/done                   : multi-step handshake
// A multi-step op performs its first step on the start edge, so an
// N-step op takes N edges and busy is high for N-1 cycles.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  univ_shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;
  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_rem;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ser_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  state_t           w_state_nxt;
  mode_t            w_mode_nxt;
  logic [CNT_W-1:0] w_rem_nxt;

  mode_t            w_step_mode;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_ser;
  logic             w_step_ser_vld;

  // While running, the latched mode drives the datapath; live inputs are ignored.
  assign w_step_mode = (r_state == RUN) ? r_mode : bus.mode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q        (r_q),
    .i_mode     (w_step_mode),
    .i_d        (bus.D),
    .i_ser_in_l (bus.ser_in_l),
    .i_ser_in_r (bus.ser_in_r),
    .o_q        (w_step_q),
    .o_ser      (w_step_ser),
    .o_ser_vld  (w_step_ser_vld)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_q     <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_state <= IDLE;
      r_mode  <= M_HOLD;
      r_rem   <= '0;
    end else begin
      r_q     <= w_q_nxt;
      r_ser   <= w_ser_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_q_nxt     = r_q;
    w_ser_nxt   = r_ser;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mode_nxt = bus.mode;
          if (bus.amount == '0) begin
            w_done_nxt = 1'b1;
            w_rem_nxt  = '0;
          end else begin
            w_q_nxt = w_step_q;
            if (w_step_ser_vld) w_ser_nxt = w_step_ser;
            if (!is_shift(bus.mode) || (bus.amount == CNT_W'(1))) begin
              w_done_nxt = 1'b1;
              w_rem_nxt  = '0;
            end else begin
              w_state_nxt = RUN;
              w_busy_nxt  = 1'b1;
              w_rem_nxt   = bus.amount - CNT_W'(1);
            end
          end
        end else if (bus.en) begin
          w_q_nxt = w_step_q;
          if (w_step_ser_vld) w_ser_nxt = w_step_ser;
        end
      end
      RUN: begin
        w_q_nxt = w_step_q;
        if (w_step_ser_vld) w_ser_nxt = w_step_ser;
        w_rem_nxt = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.Q       = r_q;
  assign bus.Q_bar   = ~r_q;
  assign bus.ser_out = r_ser;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8). The driver pushes the
// hand-computed post-edge state for every clock into a queue; a monitor
// pops one entry per falling edge and compares against the DUT outputs.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  univ_shift_reg_if #(.WIDTH(W)) bus_if ();
  univ_shift_reg #(.WIDTH(W)) dut (.Clk(Clk), .reset(reset), .bus(bus_if));

  typedef struct {
    int         id;
    logic [W-1:0] q;
    logic       ser;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_id = 0;

  task automatic cyc(input logic [W-1:0] q, input logic ser,
                     input logic busy, input logic done);
    exp_t e;
    @(posedge Clk);
    step_id++;
    e.id = step_id; e.q = q; e.ser = ser; e.busy = busy; e.done = done;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (sb.size() != 0) begin
        exp_t e;
        logic [W-1:0] qb;
        e  = sb.pop_front();
        qb = ~e.q;
        n_chk++;
        if (bus_if.Q !== e.q || bus_if.Q_bar !== qb || bus_if.ser_out !== e.ser ||
            bus_if.busy !== e.busy || bus_if.done !== e.done) begin
          n_fail++;
          $display("FAIL step%0d: got Q=%h Qb=%h ser=%b busy=%b done=%b, want Q=%h Qb=%h ser=%b busy=%b done=%b",
                   e.id, bus_if.Q, bus_if.Q_bar, bus_if.ser_out, bus_if.busy, bus_if.done,
                   e.q, qb, e.ser, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] q;
    logic         s;
    reset = 1'b0;
    bus_if.en = 1'b0; bus_if.mode = M_HOLD; bus_if.D = '0;
    bus_if.ser_in_l = 1'b0; bus_if.ser_in_r = 1'b0;
    bus_if.start = 1'b0; bus_if.amount = '0;

    // reset state, then reset from a loaded value
    cyc(8'h00, 0, 0, 0);
    reset = 1'b1; bus_if.en = 1'b1; bus_if.mode = M_LOAD; bus_if.D = 8'hA5;
    cyc(8'hA5, 0, 0, 0);
    reset = 1'b0;
    cyc(8'h00, 0, 0, 0);

    // single-step load, shift-left, hold
    reset = 1'b1; bus_if.D = 8'h96;
    cyc(8'h96, 0, 0, 0);
    bus_if.mode = M_SHL; bus_if.ser_in_r = 1'b1;
    cyc(8'h2D, 1, 0, 0);
    bus_if.en = 1'b0;
    cyc(8'h2D, 1, 0, 0);

    // ROL x3 from 0x81; mode/en changes during RUN must not matter
    bus_if.en = 1'b1; bus_if.mode = M_LOAD; bus_if.D = 8'h81;
    cyc(8'h81, 1, 0, 0);
    bus_if.en = 1'b0; bus_if.start = 1'b1; bus_if.mode = M_ROL; bus_if.amount = CW'(3);
    cyc(8'h03, 1, 1, 0);
    bus_if.start = 1'b0; bus_if.mode = M_CLR; bus_if.en = 1'b1;
    cyc(8'h06, 0, 1, 0);
    cyc(8'h0C, 0, 0, 1);

    // ASR x2 from 0x80, then back-to-back ROR x1 in the done cycle
    bus_if.mode = M_LOAD; bus_if.D = 8'h80;
    cyc(8'h80, 0, 0, 0);
    bus_if.en = 1'b0; bus_if.start = 1'b1; bus_if.mode = M_ASR; bus_if.amount = CW'(2);
    cyc(8'hC0, 0, 1, 0);
    bus_if.start = 1'b0;
    cyc(8'hE0, 0, 0, 1);
    bus_if.start = 1'b1; bus_if.mode = M_ROR; bus_if.amount = CW'(1);
    cyc(8'h70, 0, 0, 1);
    bus_if.start = 1'b0;
    cyc(8'h70, 0, 0, 0);

    // SHR x5 from 0xFF aborted by reset after 2 edges; start+en while busy ignored
    bus_if.en = 1'b1; bus_if.mode = M_LOAD; bus_if.D = 8'hFF;
    cyc(8'hFF, 0, 0, 0);
    bus_if.en = 1'b0; bus_if.start = 1'b1; bus_if.mode = M_SHR;
    bus_if.ser_in_l = 1'b0; bus_if.amount = CW'(5);
    cyc(8'h7F, 1, 1, 0);
    bus_if.en = 1'b1; bus_if.mode = M_LOAD; bus_if.D = 8'h00;
    cyc(8'h3F, 1, 1, 0);
    reset = 1'b0; bus_if.start = 1'b0; bus_if.en = 1'b0;
    cyc(8'h00, 0, 0, 0);
    reset = 1'b1;
    cyc(8'h00, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);

    // amount=0: no change, done next cycle, never busy
    bus_if.en = 1'b1; bus_if.mode = M_LOAD; bus_if.D = 8'h5A;
    cyc(8'h5A, 0, 0, 0);
    bus_if.en = 1'b0; bus_if.start = 1'b1; bus_if.mode = M_ROL; bus_if.amount = CW'(0);
    cyc(8'h5A, 0, 0, 1);
    bus_if.start = 1'b0;
    cyc(8'h5A, 0, 0, 0);

    // SHL x3 with start/en/CLR held during RUN (ignored)
    bus_if.start = 1'b1; bus_if.mode = M_SHL; bus_if.ser_in_r = 1'b0; bus_if.amount = CW'(3);
    cyc(8'hB4, 0, 1, 0);
    bus_if.en = 1'b1; bus_if.mode = M_CLR; bus_if.amount = CW'(1);
    cyc(8'h68, 1, 1, 0);
    cyc(8'hD0, 0, 0, 1);
    bus_if.start = 1'b0; bus_if.en = 1'b0;
    cyc(8'hD0, 0, 0, 0);

    // SHL x10 (> WIDTH) with ser_in_r=1: fills entirely with ones
    bus_if.start = 1'b1; bus_if.mode = M_SHL; bus_if.ser_in_r = 1'b1; bus_if.amount = CW'(10);
    q = 8'hD0;
    for (int i = 0; i < 10; i++) begin
      s = q[W-1];
      q = {q[W-2:0], 1'b1};
      cyc(q, s, (i < 9), (i == 9));
      if (i == 0) bus_if.start = 1'b0;
    end
    cyc(8'hFF, 1, 0, 0);

    for (int k = 0; k < 5 && sb.size() != 0; k++) begin
      @(negedge Clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, WIDTH bits wide, with a true/complement output pair.
- Supports hold, parallel load, logical shift, arithmetic shift right, rotate and clear.
- Single-step operations run under `en`.
- Multi-step operations shift or rotate by a programmable amount, with busy/done handshake.
- Register stage for datapath and serial-link blocks.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), width of shift-amount and remaining counter (derived; not overridden).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising Clk edge.
- en  in  1  single-step enable (ignored while busy).
- mode  in  3  operation select, encoding below.
- D  in  WIDTH  parallel load data.
- ser_in_l  in  1  serial input entering MSB on right shifts (SHR only).
- ser_in_r  in  1  serial input entering LSB on left shifts (SHL only).
- start  in  1  begin multi-step operation using mode and amount.
- amount  in  CNT_W  number of steps for multi-step operation.
- Q  out  WIDTH  register contents.
- Q_bar  out  WIDTH  always ~Q, combinational.
- ser_out  out  1  last bit shifted/rotated out, registered.
- busy  out  1  multi-step operation in progress.
- done  out  1  one-cycle pulse: multi-step operation complete.

Behaviour:
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (Q<=D)
  - 010 SHL (Q<={Q[W-2:0],ser_in_r})
  - 011 SHR (Q<={ser_in_l,Q[W-1:1]})
  - 100 ROL
  - 101 ROR
  - 110 ASR (MSB replicated)
  - 111 CLR (Q<=0)
- ser_out:
  - SHL/ROL load ser_out with the old Q[W-1].
  - SHR/ROR/ASR load ser_out with the old Q[0].
  - Other modes leave ser_out unchanged.
- Reset (reset==0 at an edge): Q=0, ser_out=0, busy=0, done=0, remaining counter=0, state IDLE. Q_bar=all ones. Reset has priority over everything and aborts any multi-step operation; no done pulse is produced.
- FSM states are IDLE and RUN.
- IDLE, start=0, en=1: one step of mode at the edge.
- IDLE, start=0, en=0: Q holds.
- IDLE, start=1: latch mode and amount (start has priority over en).
  - amount=N≥1: step 1 is performed at the same edge. If N==1, done=1 next cycle and stay IDLE. Else go RUN with remaining=N-1 and busy=1.
  - amount=0: Q unchanged, done=1 next cycle, stay IDLE.
  - Non-shift latched mode (HOLD/LOAD/CLR): executed once regardless of N, then done=1 next cycle.
- RUN, each edge:
  - Perform one step of the latched mode; mode and amount inputs are ignored.
  - Decrement remaining.
  - When remaining reaches 0: busy<=0, done<=1 for exactly one cycle, return to IDLE.
- start and en are ignored while busy=1. start is accepted in the cycle done=1 (back-to-back operations allowed).
- N>WIDTH is allowed:
  - Rotates wrap naturally.
  - SHL/SHR fill entirely with serial input.
  - ASR saturates to all-sign.
- Total latency: N edges from the start edge. busy is high N-1 cycles; done follows the final step.

Decomposition:
- Package shift_pkg:
  - mode_t enum (the 8 encodings).
  - state_t enum {IDLE, RUN}.
- Sub-module shift_step: combinational one-step function.
  - Inputs: Q, mode, ser_in_l, ser_in_r.
  - Outputs: next Q, next ser_out, ser_out-valid.
  - Instantiated once in univ_shift_reg.

Test Plan (WIDTH=8):
- Reset with Q=0xA5, reset=0 at next edge → Q=0x00, Q_bar=0xFF, busy=0, done=0, ser_out=0.
- en=1, LOAD D=0x96 → Q=0x96. Next cycle en=1, SHL, ser_in_r=1 → Q=0x2D, ser_out=1. Then en=0 → Q holds 0x2D.
- Q=0x81, start, ROL, amount=3 → Q=0x03, 0x06, 0x0C on successive edges; busy=1 for 2 cycles; done=1 one cycle after third edge. mode changed to CLR during RUN has no effect.
- Q=0x80, start, ASR, amount=2 → Q=0xC0 then 0xE0, ser_out=0, single done pulse. Immediate start, ROR, amount=1 in done cycle → Q=0x70, done pulses again.
- Q=0xFF, start, SHR, ser_in_l=0, amount=5; reset=0 after 2 edges → Q=0x00, busy=0, no done pulse ever. start with en=1 during busy in another run → ignored.
- Q=0x5A, start, amount=0 → Q stays 0x5A, done=1 next cycle, busy never asserted.
